fifo_burst_drain: RTL and testbench



---
 rtl/fifo_burst_drain.sv | 88 ++++++++
 tb/tb_fifo_burst_drain.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: drains an FWFT FIFO in header-announced bursts; defining FIFO_BURST_DRAIN_TIMEOUT_EN adds an idle-timeout start
module fifo_burst_drain #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 32,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = $clog2(FIFO_DEPTH),
    parameter int LEN_W       = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  fifo_empty_i,
    input  logic [CNT_W:0]        fifo_counter_i,
    output logic                  fifo_rd_valid_o,
    input  logic                  flush_i,
    output logic                  burst_valid_o,
    input  logic                  burst_ready_i,
    output logic [LEN_W-1:0]      burst_len_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  data_last_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_BURST);

    if (MAX_BURST < 2 || (MAX_BURST & (MAX_BURST - 1)) != 0 || MAX_BURST > FIFO_DEPTH || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("fifo_burst_drain: illegal parameters");
    end

    state_t           state;
    logic [LEN_W-1:0] beat;
    logic [LEN_W-1:0] nxt_len;
    logic             full, start, to_hit, in_data, hs;

    assign full    = fifo_counter_i >= MAX_CNT;
    assign start   = full || (flush_i && fifo_counter_i != '0) || to_hit;
    assign nxt_len = full ? '1 : LEN_W'(fifo_counter_i - 1'b1);

    assign in_data         = state == DATA;
    assign data_valid_o    = in_data && !fifo_empty_i;
    assign data_o          = in_data ? fifo_data_i : '0;
    assign hs              = data_valid_o && data_ready_i;
    assign fifo_rd_valid_o = hs;
    assign data_last_o     = data_valid_o && beat == burst_len_o;
    assign burst_valid_o   = state == HDR;
    assign busy_o          = state != IDLE;

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] timer;
    logic            partial;
    assign partial = fifo_counter_i != '0 && !full;
    assign to_hit  = partial && timer == TO_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timer <= '0;
        else     timer <= (state == IDLE && partial && !start) ? timer + 1'b1 : '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            burst_len_o <= '0;
            beat        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    burst_len_o <= nxt_len;
                    state       <= HDR;
                end
                HDR: if (burst_ready_i) begin
                    beat  <= '0;
                    state <= DATA;
                end
                DATA: if (hs) begin
                    beat <= beat + 1'b1;
                    if (beat == burst_len_o) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: table-driven and directed checks of fifo_burst_drain against a behavioural FWFT FIFO
module tb_fifo_burst_drain;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic [5:0]  fifo_counter;
    logic        fifo_rd_valid;
    logic        flush = 0;
    logic        burst_valid;
    logic        burst_ready = 0;
    logic [3:0]  burst_len;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready = 0;
    logic        data_last;
    logic        busy;

    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pop_cnt = 0;
    int          next_data = 0;
    int          exp_data = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign fifo_data    = mem[rd_ptr[5:0]];
    assign fifo_empty   = wr_ptr == rd_ptr;
    assign fifo_counter = 6'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_valid) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    fifo_burst_drain dut (
        .clk(clk), .rst(rst),
        .fifo_data_i(fifo_data), .fifo_empty_i(fifo_empty), .fifo_counter_i(fifo_counter),
        .fifo_rd_valid_o(fifo_rd_valid), .flush_i(flush),
        .burst_valid_o(burst_valid), .burst_ready_i(burst_ready), .burst_len_o(burst_len),
        .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
        .data_last_o(data_last), .busy_o(busy)
    );

    typedef struct {
        int pre;
        bit flush;
        bit hdr;
        int len;
        int hwait;
        bit toggle;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, " outs"}, {burst_valid, data_valid, data_last, fifo_rd_valid, busy}, 0);
        check({name, " len"}, burst_len, 0);
        check({name, " data"}, data, 0);
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[5:0]] = next_data;
            wr_ptr++;
            next_data++;
        end
    endtask

    task automatic wait_hdr(output bit seen, input int budget);
        for (int c = 0; c < budget && !burst_valid; c++) @(negedge clk);
        seen = burst_valid;
    endtask

    task automatic take_hdr(input int len, input int hwait);
        logic [3:0] held;
        check("hdr len", burst_len, len);
        check("hdr no pop", fifo_rd_valid, 0);
        held = burst_len;
        for (int w = 0; w < hwait; w++) begin
            @(negedge clk);
            check("hdr hold valid", burst_valid, 1);
            check("hdr hold len", burst_len, held);
        end
        burst_ready = 1;
        @(negedge clk);
        burst_ready = 0;
        check("hdr done", burst_valid, 0);
        pop_cnt = 0;
    endtask

    task automatic drain(input int len, input bit toggle, input int nbeats);
        int beats = 0;
        for (int c = 0; c < 4 * (len + 1) + 10 && beats < nbeats; c++) begin
            data_ready = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (data_valid && data_ready) begin
                check("beat data", data, exp_data);
                check("beat last", data_last, beats == len);
                check("beat pop", fifo_rd_valid, 1);
                beats++;
                exp_data++;
            end else begin
                check("idle pop", fifo_rd_valid, 0);
            end
            @(negedge clk);
        end
        data_ready = 0;
        check("beat count", beats, nbeats);
        if (nbeats == len + 1) begin
            check("pop count", pop_cnt, len + 1);
            check("end busy", busy, 0);
        end
    endtask

    initial begin
        vec_t vecs [7];
        bit   seen;
        int   cnt;
        vecs[0] = '{16, 0, 1, 15, 0, 0};
        vecs[1] = '{5, 1, 1, 4, 10, 0};
        vecs[2] = '{0, 1, 0, 0, 0, 0};
        vecs[3] = '{7, 1, 1, 6, 0, 1};
        vecs[4] = '{20, 0, 1, 15, 3, 1};
        vecs[5] = '{0, 1, 1, 3, 0, 0};
        vecs[6] = '{1, 1, 1, 0, 0, 0};

        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_zero("post reset");

        for (int v = 0; v < 7; v++) begin
            preload(vecs[v].pre);
            flush = vecs[v].flush;
            @(negedge clk);
            flush = 0;
            wait_hdr(seen, 20);
            check($sformatf("vec%0d hdr", v), seen, vecs[v].hdr);
            if (seen) begin
                take_hdr(vecs[v].len, vecs[v].hwait);
                drain(vecs[v].len, vecs[v].toggle, vecs[v].len + 1);
            end else begin
                check("empty flush busy", busy, 0);
            end
            @(negedge clk);
        end

        preload(3);
        cnt = 0;
        while (!burst_valid && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
        check("timeout delay", cnt, 64);
`else
        check("no timeout", cnt, 500);
        flush = 1;
        @(negedge clk);
        flush = 0;
`endif
        wait_hdr(seen, 5);
        check("partial hdr", seen, 1);
        take_hdr(2, 0);
        drain(2, 0, 3);
        @(negedge clk);

        preload(32);
        wait_hdr(seen, 5);
        check("chain hdr1", seen, 1);
        take_hdr(15, 0);
        drain(15, 0, 16);
        check("chain gap", burst_valid, 0);
        @(negedge clk);
        check("chain hdr2", burst_valid, 1);
        take_hdr(15, 0);
        drain(15, 0, 16);
        @(negedge clk);

        preload(32);
        wait_hdr(seen, 5);
        check("rst hdr", seen, 1);
        take_hdr(15, 0);
        drain(15, 0, 4);
        data_ready = 1;
        rst = 1;
        #1;
        check_zero("mid rst");
        @(negedge clk);
        data_ready = 0;
        rst = 0;
        wait_hdr(seen, 5);
        check("after rst hdr", seen, 1);
        take_hdr(15, 0);
        drain(15, 0, 16);
        check("left", fifo_counter, 12);
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_hdr(seen, 5);
        check("tail hdr", seen, 1);
        take_hdr(11, 0);
        drain(11, 0, 12);
        check("final empty", fifo_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
